keyb_scanner: RTL

//  Scans a 4x4 matrix keypad, synchronizes and debounces the row lines, and emits one press event per key.
//  It produces the producer side of the keypad link: a 1-cycle btn_press pulse plus btn_id = {col[3:0], row[3:0]}, each one-hot.

---
 rtl/keyb_pkg.sv | 54 +++++
 rtl/keyb_row_sync.sv | 34 +++
 rtl/keyb_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/keyb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keyb_pkg                                               |
// | Description : Shared keypad definitions: button codes, scanner FSM   |
// |               state encoding, column/row idle values and helpers.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package keyb_pkg;

    // Button codes: [7:4] one-hot column (col 3 = bit 7), [3:0] one-hot row.
    // Keypad layout (col3 .. col0):
    //   row3:  1  2  3  +
    //   row2:  4  5  6  -
    //   row1:  7  8  9  .
    //   row0:  .  0  .  =
    localparam logic [7:0] BTN_1    = 8'b1000_1000;
    localparam logic [7:0] BTN_2    = 8'b0100_1000;
    localparam logic [7:0] BTN_3    = 8'b0010_1000;
    localparam logic [7:0] BTN_PLUS = 8'b0001_1000;
    localparam logic [7:0] BTN_4    = 8'b1000_0100;
    localparam logic [7:0] BTN_5    = 8'b0100_0100;
    localparam logic [7:0] BTN_6    = 8'b0010_0100;
    localparam logic [7:0] BTN_MIN  = 8'b0001_0100;
    localparam logic [7:0] BTN_7    = 8'b1000_0010;
    localparam logic [7:0] BTN_8    = 8'b0100_0010;
    localparam logic [7:0] BTN_9    = 8'b0010_0010;
    localparam logic [7:0] BTN_0    = 8'b0100_0001;
    localparam logic [7:0] BTN_EQ   = 8'b0001_0001;

    // Scanner FSM state encoding.
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } keyb_state_t;

    // Column 3 is driven low after reset.
    localparam logic [3:0] COL_RESET = 4'b0111;

    // Raw (active-low) row lines with no key pressed.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // True when exactly one bit of a 4-bit vector is set.
    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Advance the active-low column drive 3 -> 2 -> 1 -> 0 -> 3.
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/keyb_row_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keyb_row_sync                                          |
// | Description : 4-bit two-flop synchronizer for the asynchronous,      |
// |               active-low keypad row lines. Resets to the idle level. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module keyb_row_sync
    import keyb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_row_async,
    output logic [3:0] o_row_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Two-stage capture of the pin levels; reset parks both stages at idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= ROW_IDLE;
            r_sync <= ROW_IDLE;
        end else begin
            r_meta <= i_row_async;
            r_sync <= r_meta;
        end
    end

    assign o_row_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/keyb_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keyb_scanner                                           |
// | Description : 4x4 keypad column scanner with row synchronization,    |
// |               press/release debouncing and a single press pulse per  |
// |               key. btn_id = {one-hot col, one-hot row}.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
// Parameter constraints: SCAN_DIV >= 2, DEBOUNCE_CNT >= 1.
module keyb_scanner
    import keyb_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       btn_press,
    output logic [7:0] btn_id
);

    localparam int c_SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    // The debounce counter only has to hold 0..DEBOUNCE_CNT-1: a match on a
    // tick while it sits at DEBOUNCE_CNT-1 is the moment it "reaches" the limit.
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);

    logic [3:0]          w_row_sync;
    logic [3:0]          w_rows_act;
    logic                w_tick;

    logic [c_SLOT_W-1:0] r_slot_cnt;
    keyb_state_t         r_state;
    keyb_state_t         w_state_nxt;
    logic [3:0]          r_col;
    logic [3:0]          w_col_nxt;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [c_DEB_W-1:0]  w_deb_nxt;
    logic [3:0]          r_cand_col;
    logic [3:0]          w_cand_col_nxt;
    logic [3:0]          r_cand_row;
    logic [3:0]          w_cand_row_nxt;
    logic                w_fire;
    logic                r_btn_press;
    logic [7:0]          r_btn_id;

    keyb_row_sync u_row_sync (
        .clk         (clk),
        .reset       (reset),
        .i_row_async (row_in),
        .o_row_sync  (w_row_sync)
    );

    // Rows are active-low on the pins; work with active-high internally.
    assign w_rows_act = ~w_row_sync;
    assign w_tick     = (r_slot_cnt == c_SLOT_LAST);

    // Column slot timer: one tick at the end of every SCAN_DIV-cycle slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
        end else if (w_tick) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + c_SLOT_W'(1);
        end
    end

    // Next-state logic: everything advances only on a slot tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_deb_nxt      = r_deb_cnt;
        w_cand_col_nxt = r_cand_col;
        w_cand_row_nxt = r_cand_row;
        w_fire         = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    // Multi-row readings (ghosting) are treated like idle.
                    if (is_one_hot4(w_rows_act)) begin
                        w_cand_col_nxt = ~r_col;
                        w_cand_row_nxt = w_rows_act;
                        if (DEBOUNCE_CNT == 1) begin
                            w_fire      = 1'b1;
                            w_deb_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_deb_nxt   = c_DEB_ONE;
                            w_state_nxt = DEB_PRESS;
                        end
                    end else begin
                        w_col_nxt = rotate_col(r_col);
                    end
                end
                DEB_PRESS: begin
                    if (w_rows_act == r_cand_row) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            w_fire      = 1'b1;
                            w_deb_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_deb_nxt = r_deb_cnt + c_DEB_ONE;
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_col_nxt   = rotate_col(r_col);
                        w_state_nxt = SCAN;
                    end
                end
                HELD: begin
                    // Any row activity in the frozen column restarts the release count.
                    if (w_rows_act == 4'd0) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            w_deb_nxt   = '0;
                            w_col_nxt   = rotate_col(r_col);
                            w_state_nxt = SCAN;
                        end else begin
                            w_deb_nxt = r_deb_cnt + c_DEB_ONE;
                        end
                    end else begin
                        w_deb_nxt = '0;
                    end
                end
                default: begin
                    w_deb_nxt   = '0;
                    w_col_nxt   = COL_RESET;
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    // FSM, column drive, debounce counter and candidate key registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SCAN;
            r_col      <= COL_RESET;
            r_deb_cnt  <= '0;
            r_cand_col <= 4'd0;
            r_cand_row <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_cand_col <= w_cand_col_nxt;
            r_cand_row <= w_cand_row_nxt;
        end
    end

    // Press pulse and key code register; the code is held until the next press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_press <= 1'b0;
            r_btn_id    <= 8'h00;
        end else begin
            r_btn_press <= w_fire;
            if (w_fire) begin
                r_btn_id <= {w_cand_col_nxt, w_cand_row_nxt};
            end
        end
    end

    assign col_out   = r_col;
    assign btn_press = r_btn_press;
    assign btn_id    = r_btn_id;

endmodule
`default_nettype wire
